// File: rtl/tqvp_conditioner_pkg.sv
// Shared FSM encoding and register bit positions for the input conditioner.
package tqvp_conditioner_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } cond_state_t;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_SEL_LSB     = 1;
    localparam int CTRL_SEL_MSB     = 3;

    localparam int STATUS_CLEAN_BIT = 0;
    localparam int STATUS_RISE_BIT  = 1;
    localparam int STATUS_FALL_BIT  = 2;

    localparam logic [7:0] THRESH_RESET = 8'h04;

endpackage

// File: rtl/tqvp_sync2.sv
// Two-flop synchronizer for one asynchronous pin; output lags input by two clocks.
module tqvp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/tqvp_input_conditioner.sv
// Selectable-pin debouncer with edge pulses and sticky edge flags.
// Define CONDITIONER_PRESCALE_EN to add the programmable tick prescaler.
module tqvp_input_conditioner
    import tqvp_conditioner_pkg::*;
#(
    parameter logic [3:0] ADDR_CTRL     = 4'h0,
    parameter logic [3:0] ADDR_THRESH   = 4'h1,
    parameter logic [3:0] ADDR_STATUS   = 4'h2,
    parameter logic [3:0] ADDR_PRESCALE = 4'h3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       clean_out,
    output logic       rise_pulse,
    output logic       fall_pulse
);

    logic        en_q, en_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  thresh_q, thresh_d;
    cond_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        clean_q, clean_d;
    logic        rise_q, rise_d;
    logic        fall_q, fall_d;
    logic        rise_seen_q, rise_seen_d;
    logic        fall_seen_q, fall_seen_d;

    logic        sync;
    logic        tick;
    logic        commit;
    logic [8:0]  cnt_inc;
    logic        wr_ctrl, wr_thresh, wr_status;

    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_thresh = data_write && (address == ADDR_THRESH);
    assign wr_status = data_write && (address == ADDR_STATUS);

    tqvp_sync2 u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (ui_in[sel_q]),
        .q_out (sync)
    );

`ifdef CONDITIONER_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
    logic       wr_prescale;

    assign wr_prescale = data_write && (address == ADDR_PRESCALE);

    always_comb begin
        tick        = (presc_cnt_q == prescale_q);
        presc_cnt_d = tick ? 8'h00 : presc_cnt_q + 8'h01;
        prescale_d  = wr_prescale ? data_in : prescale_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q  <= 8'h00;
            presc_cnt_q <= 8'h00;
        end else begin
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end
`else
    always_comb begin
        tick = 1'b1;
    end
`endif

    always_comb begin
        en_d     = wr_ctrl ? data_in[CTRL_EN_BIT] : en_q;
        sel_d    = wr_ctrl ? data_in[CTRL_SEL_MSB:CTRL_SEL_LSB] : sel_q;
        thresh_d = wr_thresh ? data_in : thresh_q;
    end

    // Debounce FSM; the comparison uses 9 bits so a saturated count still compares correctly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        commit  = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 9'd1;

        if (!en_q) begin
            state_d = ST_STABLE;
            cnt_d   = 8'h00;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (sync != clean_q) begin
                        if (thresh_q == 8'h00) begin
                            commit = 1'b1;
                        end else begin
                            state_d = ST_CHECK;
                            cnt_d   = 8'h00;
                        end
                    end
                end
                ST_CHECK: begin
                    if (sync == clean_q) begin
                        state_d = ST_STABLE;
                    end else if (tick) begin
                        cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_inc[7:0];
                        if (cnt_inc >= {1'b0, thresh_q}) begin
                            commit  = 1'b1;
                            state_d = ST_STABLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = 8'h00;
                end
            endcase
        end

        if (commit) begin
            clean_d = sync;
            rise_d  = sync;
            fall_d  = !sync;
        end
    end

    // A flag being set wins over a simultaneous write-1-to-clear.
    always_comb begin
        rise_seen_d = rise_d | (rise_seen_q & ~(wr_status & data_in[STATUS_RISE_BIT]));
        fall_seen_d = fall_d | (fall_seen_q & ~(wr_status & data_in[STATUS_FALL_BIT]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STABLE;
            cnt_q       <= 8'h00;
            clean_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rise_seen_q <= 1'b0;
            fall_seen_q <= 1'b0;
            en_q        <= 1'b0;
            sel_q       <= 3'd0;
            thresh_q    <= THRESH_RESET;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clean_q     <= clean_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rise_seen_q <= rise_seen_d;
            fall_seen_q <= fall_seen_d;
            en_q        <= en_d;
            sel_q       <= sel_d;
            thresh_q    <= thresh_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    always_comb begin
        data_out = 8'h00;
        if (address == ADDR_CTRL) begin
            data_out = {4'b0000, sel_q, en_q};
        end else if (address == ADDR_THRESH) begin
            data_out = thresh_q;
        end else if (address == ADDR_STATUS) begin
            data_out = {5'b00000, fall_seen_q, rise_seen_q, clean_q};
        end else if (address == ADDR_PRESCALE) begin
`ifdef CONDITIONER_PRESCALE_EN
            data_out = prescale_q;
`else
            data_out = 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_tqvp_input_conditioner.sv
// Directed bench for tqvp_input_conditioner; inputs change and outputs are sampled on the falling edge.
module tb_tqvp_input_conditioner;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_THRESH = 4'h1;
    localparam logic [3:0] A_STATUS = 4'h2;
    localparam logic [3:0] A_PRESC  = 4'h3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       clean_out, rise_pulse, fall_pulse;

    int errors = 0;
    int checks = 0;

    tqvp_input_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        cyc(1);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        ui_in      = 8'h00;
        data_write = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        cyc(2);
        checks++;
        if ({clean_out, rise_pulse, fall_pulse} !== 3'b000) begin
            $display("FAIL reset_outputs: got %b want 000", {clean_out, rise_pulse, fall_pulse});
            errors++;
        end
        rd(A_CTRL, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL reset_ctrl: got %h want 00", v); errors++; end
        rd(A_THRESH, v);
        checks++;
        if (v !== 8'h04) begin $display("FAIL reset_thresh: got %h want 04", v); errors++; end
        rd(A_STATUS, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL reset_status: got %h want 00", v); errors++; end
        rd(A_PRESC, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL reset_prescale: got %h want 00", v); errors++; end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rise();
        logic [7:0] v;
        reset_dut();
        wr(A_CTRL, 8'h01);
        cyc(3);
        ui_in[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            checks++;
            if (clean_out !== 1'b0 || rise_pulse !== 1'b0) begin
                $display("FAIL rise_early edge %0d: clean=%b pulse=%b want 0 0", i, clean_out, rise_pulse);
                errors++;
            end
        end
        cyc(1);
        checks++;
        if ({clean_out, rise_pulse, fall_pulse} !== 3'b110) begin
            $display("FAIL rise_commit: got %b want 110", {clean_out, rise_pulse, fall_pulse});
            errors++;
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 8'h03) begin $display("FAIL rise_status: got %h want 03", v); errors++; end
        cyc(1);
        checks++;
        if ({clean_out, rise_pulse} !== 2'b10) begin
            $display("FAIL rise_pulse_width: got %b want 10", {clean_out, rise_pulse});
            errors++;
        end
    endtask

    task automatic test_sticky_priority();
        logic [7:0] v;
        ui_in[0] = 1'b0;
        cyc(6);
        checks++;
        if (clean_out !== 1'b1) begin $display("FAIL fall_early: got %b want 1", clean_out); errors++; end
        wr(A_STATUS, 8'h02);
        checks++;
        if ({clean_out, rise_pulse, fall_pulse} !== 3'b001) begin
            $display("FAIL fall_commit: got %b want 001", {clean_out, rise_pulse, fall_pulse});
            errors++;
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 8'h04) begin $display("FAIL sticky_priority_status: got %h want 04", v); errors++; end
    endtask

    task automatic test_glitch();
        logic [7:0] v;
        logic seen;
        reset_dut();
        wr(A_CTRL, 8'h01);
        cyc(3);
        ui_in[0] = 1'b1;
        cyc(3);
        ui_in[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (clean_out || rise_pulse || fall_pulse) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin $display("FAIL glitch_activity: got %b want 0", seen); errors++; end
        rd(A_STATUS, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL glitch_status: got %h want 00", v); errors++; end
    endtask

    task automatic test_thresh_zero();
        reset_dut();
        wr(A_CTRL, 8'h01);
        wr(A_THRESH, 8'h00);
        cyc(2);
        ui_in[0] = 1'b1;
        cyc(2);
        checks++;
        if (clean_out !== 1'b0) begin $display("FAIL t0_rise_early: got %b want 0", clean_out); errors++; end
        cyc(1);
        checks++;
        if ({clean_out, rise_pulse} !== 2'b11) begin
            $display("FAIL t0_rise: got %b want 11", {clean_out, rise_pulse});
            errors++;
        end
        ui_in[0] = 1'b0;
        cyc(2);
        checks++;
        if (clean_out !== 1'b1) begin $display("FAIL t0_fall_early: got %b want 1", clean_out); errors++; end
        cyc(1);
        checks++;
        if ({clean_out, fall_pulse} !== 2'b01) begin
            $display("FAIL t0_fall: got %b want 01", {clean_out, fall_pulse});
            errors++;
        end
    endtask

    task automatic test_thresh_change();
        wr(A_THRESH, 8'hC8);
        cyc(2);
        ui_in[0] = 1'b1;
        cyc(8);
        checks++;
        if (clean_out !== 1'b0) begin $display("FAIL tchg_hold200: got %b want 0", clean_out); errors++; end
        wr(A_THRESH, 8'h02);
        checks++;
        if (clean_out !== 1'b0) begin $display("FAIL tchg_write_edge: got %b want 0", clean_out); errors++; end
        cyc(1);
        checks++;
        if ({clean_out, rise_pulse} !== 2'b11) begin
            $display("FAIL tchg_commit: got %b want 11", {clean_out, rise_pulse});
            errors++;
        end
    endtask

    task automatic test_sel_enable();
        logic [7:0] v;
        logic seen;
        reset_dut();
        ui_in = 8'h08;
        cyc(5);
        checks++;
        if (clean_out !== 1'b0) begin $display("FAIL disabled_hold0: got %b want 0", clean_out); errors++; end
        wr(A_THRESH, 8'h00);
        wr(A_CTRL, 8'h07);
        rd(A_CTRL, v);
        checks++;
        if (v !== 8'h07) begin $display("FAIL ctrl_readback: got %h want 07", v); errors++; end
        cyc(2);
        checks++;
        if (clean_out !== 1'b0) begin $display("FAIL sel3_early: got %b want 0", clean_out); errors++; end
        cyc(1);
        checks++;
        if (clean_out !== 1'b1) begin $display("FAIL sel3_commit: got %b want 1", clean_out); errors++; end
        wr(A_CTRL, 8'h06);
        ui_in = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (rise_pulse || fall_pulse) seen = 1'b1;
        end
        checks++;
        if ({clean_out, seen} !== 2'b10) begin
            $display("FAIL disabled_hold1: clean,pulse got %b want 10", {clean_out, seen});
            errors++;
        end
        wr(A_CTRL, 8'hFF);
        rd(A_CTRL, v);
        checks++;
        if (v !== 8'h0F) begin $display("FAIL ctrl_upper_zero: got %h want 0f", v); errors++; end
        rd(4'hF, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL unmapped_read: got %h want 00", v); errors++; end
    endtask

    task automatic test_reset_mid_check();
        logic [7:0] v;
        logic seen;
        reset_dut();
        wr(A_THRESH, 8'h00);
        wr(A_CTRL, 8'h01);
        ui_in[0] = 1'b1;
        cyc(4);
        wr(A_THRESH, 8'h04);
        ui_in[0] = 1'b0;
        cyc(4);
        checks++;
        if (clean_out !== 1'b1) begin $display("FAIL rmc_pre: got %b want 1", clean_out); errors++; end
        rst = 1'b1;
        #1;
        checks++;
        if ({clean_out, rise_pulse, fall_pulse} !== 3'b000) begin
            $display("FAIL rmc_async_outputs: got %b want 000", {clean_out, rise_pulse, fall_pulse});
            errors++;
        end
        rd(A_CTRL, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL rmc_ctrl: got %h want 00", v); errors++; end
        rd(A_THRESH, v);
        checks++;
        if (v !== 8'h04) begin $display("FAIL rmc_thresh: got %h want 04", v); errors++; end
        rd(A_STATUS, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL rmc_status: got %h want 00", v); errors++; end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (clean_out || rise_pulse || fall_pulse) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin $display("FAIL rmc_after_release: got %b want 0", seen); errors++; end
    endtask

    task automatic test_prescale();
        logic [7:0] v;
`ifdef CONDITIONER_PRESCALE_EN
        int commit_at;
        int pulses;
        reset_dut();
        wr(A_CTRL, 8'h01);
        wr(A_PRESC, 8'h03);
        rd(A_PRESC, v);
        checks++;
        if (v !== 8'h03) begin $display("FAIL prescale_readback: got %h want 03", v); errors++; end
        wr(A_THRESH, 8'h02);
        cyc(3);
        ui_in[0] = 1'b1;
        commit_at = 0;
        pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc(1);
            if (rise_pulse) pulses++;
            if (clean_out && commit_at == 0) commit_at = i;
        end
        checks++;
        if (commit_at < 8 || commit_at > 11) begin
            $display("FAIL prescale_commit_edge: got %0d want 8..11", commit_at);
            errors++;
        end
        checks++;
        if (pulses != 1) begin $display("FAIL prescale_pulses: got %0d want 1", pulses); errors++; end
`else
        reset_dut();
        wr(A_PRESC, 8'h55);
        rd(A_PRESC, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL prescale_absent: got %h want 00", v); errors++; end
`endif
    endtask

    initial begin
        test_reset();
        test_rise();
        test_sticky_priority();
        test_glitch();
        test_thresh_zero();
        test_thresh_change();
        test_sel_enable();
        test_reset_mid_check();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
